// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
// Shared constants for the RTC bus responder: register map addresses and
// the BCD roll-over limits used by the time-of-day chain.
// No ports (package).
package rtc_bus_pkg;

    localparam logic [7:0] ADDR_SEG     = 8'h21;
    localparam logic [7:0] ADDR_MIN     = 8'h22;
    localparam logic [7:0] ADDR_HORA    = 8'h23;
    localparam logic [7:0] SCRATCH_LAST = 8'h0F;

    localparam logic [7:0] SEC_MIN_LIMIT = 8'h59;
    localparam logic [7:0] HORA_LIMIT    = 8'h23;

    // Scratch RAM occupies the bottom 16 addresses.
    function automatic logic is_scratch(input logic [7:0] addr);
        return addr <= SCRATCH_LAST;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// rtc_bus_responder_if
// Control strobes of the multiplexed RTC bus. The shared dato lines are a
// tri-state net and stay a plain inout port on the responder.
//   cs_n   : chip select, active low
//   rd_n   : read strobe, active low
//   wr_n   : write strobe, active low
//   ad_sel : 0 = address phase, 1 = data phase
// modport master : host side (drives the strobes)
// modport slave  : device side (samples the strobes)
interface rtc_bus_responder_if;

    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic ad_sel;

    modport master (output cs_n, rd_n, wr_n, ad_sel);
    modport slave  (input  cs_n, rd_n, wr_n, ad_sel);

endinterface

// File: rtl/rtc_bcd_incrementer.sv
// rtc_bcd_incrementer
// One stage of the BCD time-of-day chain. Purely combinational.
//   value     in  8  current field value
//   limit     in  8  last legal value before wrap (0x59 or 0x23)
//   carry_in  in  1  advance request for this field
//   next      out 8  field value after the (optional) advance
//   carry_out out 1  field wrapped, advance the next field
module rtc_bcd_incrementer (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    input  logic       carry_in,
    output logic [7:0] next,
    output logic       carry_out
);

    // The limit compare is a raw binary compare, so anything the host wrote
    // at or above the limit (valid BCD or not) wraps to zero. A low nibble of
    // 9 or more carries into the high nibble, which also cleans up A..F digits.
    always_comb begin
        next      = value;
        carry_out = 1'b0;
        if (carry_in) begin
            if (value >= limit) begin
                next      = 8'h00;
                carry_out = 1'b1;
            end else if (value[3:0] >= 4'd9) begin
                next = {value[7:4] + 4'd1, 4'h0};
            end else begin
                next = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
// Device end of the multiplexed 8-bit RTC bus. Latches an address cycle,
// then serves data writes/reads against 16 bytes of scratch RAM and a
// free-running BCD seconds/minutes/hours clock.
//   clk      in     1  system clock, rising edge
//   reset_n  in     1  asynchronous active-low reset
//   bus      slave     cs_n / rd_n / wr_n / ad_sel strobes
//   dato     inout  8  shared address/data lines, driven only during a read
//   addr_q   out    8  currently latched address
//   tick_1s  out    1  one-cycle pulse on each time advance
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rtc_bus_responder_if.slave        bus,
    inout  wire  [7:0]                dato,
    output logic [7:0]                addr_q,
    output logic                      tick_1s
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [1:0] cs_sync, rd_sync, wr_sync, ad_sync;
    logic       wr_prev;
    logic [7:0] dato_s1;
    logic       cs_s, rd_s, wr_s, ad_s;
    logic       wr_event, read_ok;

    logic [7:0] scratch [16];
    logic [7:0] seg_q, min_q, hora_q;
    logic [7:0] seg_next, min_next, hora_next;
    logic       seg_carry, min_carry, hora_carry_unused;
    logic [7:0] rd_value;

    logic [DIV_W-1:0] div_cnt;
    logic             oe;
    logic [7:0]       snap_q;

    // Strobes idle high after reset so that releasing reset never looks
    // like a rising write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync <= 2'b11;
            rd_sync <= 2'b11;
            wr_sync <= 2'b11;
            ad_sync <= 2'b00;
            wr_prev <= 1'b1;
            dato_s1 <= 8'h00;
        end else begin
            cs_sync <= {cs_sync[0], bus.cs_n};
            rd_sync <= {rd_sync[0], bus.rd_n};
            wr_sync <= {wr_sync[0], bus.wr_n};
            ad_sync <= {ad_sync[0], bus.ad_sel};
            wr_prev <= wr_sync[1];
            dato_s1 <= dato;
        end
    end

    assign cs_s = cs_sync[1];
    assign rd_s = rd_sync[1];
    assign wr_s = wr_sync[1];
    assign ad_s = ad_sync[1];

    // A write commits on the rising edge of the synced strobe; holding rd_n
    // low at the same time makes the cycle illegal and suppresses it.
    assign wr_event = wr_s & ~wr_prev & ~cs_s & rd_s;
    assign read_ok  = ~cs_s & ~rd_s & wr_s & ad_s;

    // Divider terminal count drives both the tick output and the seconds carry.
    assign tick_1s = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick_1s) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    rtc_bcd_incrementer u_inc_seg (
        .value     (seg_q),
        .limit     (SEC_MIN_LIMIT),
        .carry_in  (tick_1s),
        .next      (seg_next),
        .carry_out (seg_carry)
    );

    rtc_bcd_incrementer u_inc_min (
        .value     (min_q),
        .limit     (SEC_MIN_LIMIT),
        .carry_in  (seg_carry),
        .next      (min_next),
        .carry_out (min_carry)
    );

    rtc_bcd_incrementer u_inc_hora (
        .value     (hora_q),
        .limit     (HORA_LIMIT),
        .carry_in  (min_carry),
        .next      (hora_next),
        .carry_out (hora_carry_unused)
    );

    // Time fields advance every cycle through the chain; a host write to a
    // field is assigned afterwards so it wins over a simultaneous tick, while
    // carries already computed from the old value still reach other fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 8'h00;
            seg_q  <= 8'h00;
            min_q  <= 8'h00;
            hora_q <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                scratch[i] <= 8'h00;
            end
        end else begin
            seg_q  <= seg_next;
            min_q  <= min_next;
            hora_q <= hora_next;
            if (wr_event && !ad_s) begin
                addr_q <= dato_s1;
            end
            if (wr_event && ad_s) begin
                if (is_scratch(addr_q)) begin
                    scratch[addr_q[3:0]] <= dato_s1;
                end
                case (addr_q)
                    ADDR_SEG:  seg_q  <= dato_s1;
                    ADDR_MIN:  min_q  <= dato_s1;
                    ADDR_HORA: hora_q <= dato_s1;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        rd_value = 8'h00;
        if (is_scratch(addr_q)) begin
            rd_value = scratch[addr_q[3:0]];
        end else begin
            case (addr_q)
                ADDR_SEG:  rd_value = seg_q;
                ADDR_MIN:  rd_value = min_q;
                ADDR_HORA: rd_value = hora_q;
                default:   rd_value = 8'h00;
            endcase
        end
    end

    // The snapshot is taken only as oe rises, so a read held across a tick
    // keeps returning the value seen at the start of the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe     <= 1'b0;
            snap_q <= 8'h00;
        end else begin
            oe <= read_ok;
            if (read_ok && !oe) begin
                snap_q <= rd_value;
            end
        end
    end

    assign dato = oe ? snap_q : 8'hzz;

endmodule
